cpu_fsm_controller: RTL and testbench

//  Instruction register, decoder and Moore FSM sitting directly upstream of the datapath.

---
 rtl/cpu_fsm_controller.sv | 164 ++++++++++++++++
 tb/tb_cpu_fsm_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fsm_controller.sv
// Instruction register, decoder and Moore sequencer that drives the datapath controls.
// Control outputs are registered alongside the state; load/write strobes are gated by reset.
module cpu_fsm_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_DECODE = 3'd1,
        ST_WIMM   = 3'd2,
        ST_GETA   = 3'd3,
        ST_GETB   = 3'd4,
        ST_EXEC   = 3'd5,
        ST_WREG   = 3'd6
    } state_t;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       loadc;
        logic       loads;
        logic       write;
    } ctrl_t;

    state_t      r_state;
    logic [15:0] r_ir;
    ctrl_t       r_ctrl;
    state_t      w_next_state;

    function automatic state_t next_state_f(input state_t st, input logic start,
                                            input logic [2:0] opcode, input logic [1:0] op);
        state_t nxt;
        nxt = ST_WAIT;
        case (st)
            ST_WAIT:   nxt = start ? ST_DECODE : ST_WAIT;
            ST_DECODE: begin
                case ({opcode, op})
                    5'b110_10:                       nxt = ST_WIMM;
                    5'b110_00, 5'b101_11:            nxt = ST_GETB;
                    5'b101_00, 5'b101_01, 5'b101_10: nxt = ST_GETA;
                    default:                         nxt = ST_WAIT;
                endcase
            end
            ST_WIMM:   nxt = ST_WAIT;
            ST_GETA:   nxt = ST_GETB;
            ST_GETB:   nxt = ST_EXEC;
            ST_EXEC:   nxt = ({opcode, op} == 5'b101_01) ? ST_WAIT : ST_WREG;
            ST_WREG:   nxt = ST_WAIT;
            default:   nxt = ST_WAIT;
        endcase
        return nxt;
    endfunction

    // Control word presented while sitting in state st with instruction ir.
    function automatic ctrl_t ctrl_for(input state_t st, input logic [15:0] ir);
        ctrl_t c;
        c = '0;
        case (st)
            ST_WAIT:   c.w = 1'b1;
            ST_DECODE: c.w = 1'b0;
            ST_WIMM: begin
                c.vsel     = 2'b01;
                c.writenum = ir[10:8];
                c.write    = 1'b1;
            end
            ST_GETA: begin
                c.readnum = ir[10:8];
                c.loada   = 1'b1;
            end
            ST_GETB: begin
                c.readnum = ir[2:0];
                c.loadb   = 1'b1;
            end
            ST_EXEC: begin
                c.shift = ir[4:3];
                c.loadc = 1'b1;
                if (ir[15:13] == 3'b110) begin
                    c.asel  = 1'b1;
                    c.aluop = 2'b00;
                end else begin
                    c.aluop = ir[12:11];
                    c.asel  = (ir[12:11] == 2'b11);
                end
                if (ir[15:11] == 5'b101_01) begin
                    c.loads = 1'b1;
                    c.loadc = 1'b0;
                end else begin
                    c.loads = 1'b0;
                end
            end
            ST_WREG: begin
                c.vsel     = 2'b11;
                c.writenum = ir[7:5];
                c.write    = 1'b1;
            end
            default:   c.w = 1'b0;
        endcase
        return c;
    endfunction

    assign w_next_state = next_state_f(r_state, s, r_ir[15:13], r_ir[12:11]);

    // State, IR and registered controls; the WAIT->DECODE step may use the old IR
    // because DECODE's controls do not depend on it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_WAIT;
            r_ir    <= 16'h0000;
            r_ctrl  <= ctrl_for(ST_WAIT, 16'h0000);
        end else begin
            r_state <= w_next_state;
            r_ctrl  <= ctrl_for(w_next_state, r_ir);
            if ((r_state == ST_WAIT) && load) begin
                r_ir <= in;
            end else begin
                r_ir <= r_ir;
            end
        end
    end

    assign w        = r_ctrl.w;
    assign readnum  = r_ctrl.readnum;
    assign writenum = r_ctrl.writenum;
    assign vsel     = r_ctrl.vsel;
    assign asel     = r_ctrl.asel;
    assign bsel     = r_ctrl.bsel;
    assign shift    = r_ctrl.shift;
    assign ALUop    = r_ctrl.aluop;
    assign loada    = r_ctrl.loada & reset_n;
    assign loadb    = r_ctrl.loadb & reset_n;
    assign loadc    = r_ctrl.loadc & reset_n;
    assign loads    = r_ctrl.loads & reset_n;
    assign write    = r_ctrl.write & reset_n;
    assign sximm8   = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5   = {{11{r_ir[4]}}, r_ir[4:0]};

endmodule

// File: tb/tb_cpu_fsm_controller.sv
// Self-checking bench for cpu_fsm_controller: spec vector table, corner sequences
// and random instructions against an instruction-level sequence model.
module tb_cpu_fsm_controller;

    logic        clk;
    logic        reset_n;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic        write;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    int checks = 0;
    int errors = 0;

    cpu_fsm_controller dut (
        .clk(clk), .reset_n(reset_n), .s(s), .load(load), .in(in), .w(w),
        .readnum(readnum), .writenum(writenum), .vsel(vsel), .loada(loada),
        .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
        .loadc(loadc), .loads(loads), .write(write), .sximm8(sximm8), .sximm5(sximm5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       loadc;
        logic       loads;
        logic       write;
    } ctl_t;

    typedef struct {
        logic [15:0] instr;
        int          latency;
        logic [15:0] sx8;
        logic [15:0] sx5;
    } vec_t;

    ctl_t exp_q[$];

    function automatic ctl_t act_ctl();
        return {w, readnum, writenum, vsel, loada, loadb, asel, bsel, shift, ALUop,
                loadc, loads, write};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string name, input ctl_t e);
        ctl_t a;
        a = act_ctl();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, a, e);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, a, e);
        end
    endtask

    // Edges from s to the return to WAIT, straight from the instruction latency table.
    function automatic int latency_of(input logic [15:0] ir);
        case (ir[15:11])
            5'b110_10:            return 3;
            5'b110_00, 5'b101_11: return 5;
            5'b101_01:            return 5;
            5'b101_00, 5'b101_10: return 6;
            default:              return 2;
        endcase
    endfunction

    // Build the per-cycle control stream an instruction should produce after s.
    function automatic void build_model(input logic [15:0] ir);
        ctl_t c;
        bit is_movi, is_movr, is_mvn, is_cmp, is_alu;
        is_movi = (ir[15:11] == 5'b110_10);
        is_movr = (ir[15:11] == 5'b110_00);
        is_mvn  = (ir[15:11] == 5'b101_11);
        is_cmp  = (ir[15:11] == 5'b101_01);
        is_alu  = (ir[15:13] == 3'b101);
        exp_q.delete();
        c = '0;
        exp_q.push_back(c);
        if (is_movi) begin
            c = '0; c.vsel = 2'b01; c.writenum = ir[10:8]; c.write = 1'b1;
            exp_q.push_back(c);
        end else if (is_movr || is_alu) begin
            if (!is_movr && !is_mvn) begin
                c = '0; c.readnum = ir[10:8]; c.loada = 1'b1;
                exp_q.push_back(c);
            end
            c = '0; c.readnum = ir[2:0]; c.loadb = 1'b1;
            exp_q.push_back(c);
            c = '0; c.shift = ir[4:3];
            c.aluop = is_movr ? 2'b00 : ir[12:11];
            c.asel  = is_movr || is_mvn;
            c.loadc = !is_cmp;
            c.loads = is_cmp;
            exp_q.push_back(c);
            if (!is_cmp) begin
                c = '0; c.vsel = 2'b11; c.writenum = ir[7:5]; c.write = 1'b1;
                exp_q.push_back(c);
            end
        end
        c = '0; c.w = 1'b1;
        exp_q.push_back(c);
    endfunction

    task automatic run_instr(input logic [15:0] ir, input bit load_with_s, input bit stray,
                             input int exp_lat, input logic [15:0] e8, input logic [15:0] e5);
        int edges;
        int k;
        logic [31:0] rnd;
        ctl_t waitv;
        build_model(ir);
        waitv = '0; waitv.w = 1'b1;
        load = 1'b1; in = ir;
        if (!load_with_s) begin
            s = 1'b0;
            tick();
            load = 1'b0;
            chk_ctl("preload_idle", waitv);
        end
        s = 1'b1;
        tick();
        s = 1'b0; load = 1'b0;
        edges = 1;
        chk16("sximm8", sximm8, e8);
        chk16("sximm5", sximm5, e5);
        k = 0;
        while (1) begin
            if (k < exp_q.size()) chk_ctl($sformatf("seq_%h_%0d", ir, k), exp_q[k]);
            k++;
            if (w === 1'b1 || edges >= 20) break;
            if (stray) begin
                rnd = $urandom;
                load = rnd[16]; in = rnd[15:0];
            end
            tick();
            edges++;
        end
        load = 1'b0;
        checks++;
        if (edges != exp_lat || w !== 1'b1) begin
            errors++;
            $display("FAIL latency_%h got=%0d want=%0d w=%b", ir, edges, exp_lat, w);
        end
    endtask

    initial begin
        vec_t        tbl[7];
        ctl_t        waitv;
        int          n;
        logic [31:0] rnd;
        logic [2:0]  opc;
        logic [1:0]  op;
        logic [15:0] ir;
        logic [15:0] e8;
        logic [15:0] e5;

        tbl[0] = '{16'hD2F6, 3, 16'hFFF6, 16'hFFF6};
        tbl[1] = '{16'hA1A8, 6, 16'hFFA8, 16'h0008};
        tbl[2] = '{16'hAB03, 5, 16'h0003, 16'h0003};
        tbl[3] = '{16'hC0E4, 5, 16'hFFE4, 16'h0004};
        tbl[4] = '{16'hFFFF, 2, 16'hFFFF, 16'hFFFF};
        tbl[5] = '{16'hB862, 5, 16'h0062, 16'h0002};
        tbl[6] = '{16'hB143, 6, 16'h0043, 16'h0003};

        waitv = '0; waitv.w = 1'b1;
        reset_n = 1'b0; s = 1'b0; load = 1'b0; in = 16'h0000;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk_ctl("reset_idle", waitv);
        chk16("reset_sximm8", sximm8, 16'h0000);
        chk16("reset_sximm5", sximm5, 16'h0000);

        for (int i = 0; i < 7; i++) begin
            run_instr(tbl[i].instr, (i % 2) == 0, 1'b0, tbl[i].latency, tbl[i].sx8, tbl[i].sx5);
        end

        // IR must ignore load outside WAIT; reset in WREG suppresses the write.
        load = 1'b1; in = 16'hA1A8; s = 1'b1;
        tick();
        load = 1'b0; s = 1'b0;
        tick();
        tick();
        load = 1'b1; in = 16'hD2F6;
        tick();
        load = 1'b0;
        chk16("ir_hold_getb", sximm8, 16'hFFA8);
        tick();
        checks++;
        if (write !== 1'b1 || writenum !== 3'd5 || vsel !== 2'b11) begin
            errors++;
            $display("FAIL wreg_reached got=%b/%0d/%b want=1/5/11", write, writenum, vsel);
        end
        reset_n = 1'b0;
        #1;
        chk16("rst_mask_strobes", {11'h000, loada, loadb, loadc, loads, write}, 16'h0000);
        tick();
        chk_ctl("rst_mid_state", waitv);
        chk16("rst_mid_ir", sximm8, 16'h0000);
        reset_n = 1'b1;
        tick();
        chk_ctl("rst_mid_idle", waitv);

        // Back-to-back: s held high restarts the same IR straight from WAIT.
        load = 1'b1; in = 16'hC0E4; s = 1'b1;
        tick();
        load = 1'b0;
        for (int e = 2; e <= 5; e++) tick();
        chk16("b2b_wait", {15'h0000, w}, 16'h0001);
        tick();
        chk16("b2b_restart", {15'h0000, w}, 16'h0000);
        tick();
        chk16("b2b_getb", {12'h000, loadb, readnum}, 16'h000C);
        s = 1'b0;
        n = 0;
        while (w !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk16("b2b_drain", {15'h0000, w}, 16'h0001);

        for (int i = 0; i < 60; i++) begin
            rnd = $urandom;
            case (rnd[31:29] % 3'd7)
                3'd0:    begin opc = 3'b110; op = 2'b10; end
                3'd1:    begin opc = 3'b110; op = 2'b00; end
                3'd2:    begin opc = 3'b101; op = 2'b00; end
                3'd3:    begin opc = 3'b101; op = 2'b01; end
                3'd4:    begin opc = 3'b101; op = 2'b10; end
                3'd5:    begin opc = 3'b101; op = 2'b11; end
                default: begin opc = rnd[15:13]; op = rnd[12:11]; end
            endcase
            ir = {opc, op, rnd[10:0]};
            e8 = 16'($signed(ir[7:0]));
            e5 = 16'($signed(ir[4:0]));
            run_instr(ir, rnd[27], rnd[26], latency_of(ir), e8, e5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
